// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment with wrap, jump, call/ret via LIFO return stack, stall.
// One-cycle latency from command edge to o_pc; all outputs registered, no combinational input paths.
module pc_seq_unit #(
  parameter int PC_BITS     = 8,
  parameter int MEM_DEPTH   = 56,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_nrst,
  input  logic                               i_stall,
  input  logic                               i_jump,
  input  logic                               i_call,
  input  logic                               i_ret,
  input  logic [PC_BITS-1:0]                 i_target,
  input  logic                               i_clr_err,
  output logic [PC_BITS-1:0]                 o_pc,
  output logic                               o_pc_valid,
  output logic                               o_wrap,
  output logic                               o_addr_err,
  output logic                               o_stack_ovf,
  output logic                               o_stack_unf,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_stack_lvl
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  // One extra bit so MEM_DEPTH == 2**PC_BITS still compares correctly.
  localparam logic [PC_BITS:0]   DEPTH_X = (PC_BITS+1)'(MEM_DEPTH);
  localparam logic [PC_BITS-1:0] LAST    = PC_BITS'(MEM_DEPTH - 1);
  localparam logic [LVL_W-1:0]   FULL    = LVL_W'(STACK_DEPTH);

  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               valid_q;
  logic               wrap_q, wrap_d;
  logic               addr_err_q, addr_err_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               push;
  logic [PC_BITS-1:0] pc_inc;
  logic               at_last;
  logic               tgt_ok;
  logic               full;
  logic [PC_BITS-1:0] stack_q [STACK_DEPTH];

  assign at_last = (pc_q == LAST);
  assign pc_inc  = at_last ? '0 : pc_q + 1'b1;
  assign tgt_ok  = ({1'b0, i_target} < DEPTH_X);
  assign full    = (lvl_q == FULL);

  always_comb begin
    pc_d       = pc_q;
    lvl_d      = lvl_q;
    wrap_d     = 1'b0;
    push       = 1'b0;
    addr_err_d = i_clr_err ? 1'b0 : addr_err_q;
    ovf_d      = i_clr_err ? 1'b0 : ovf_q;
    unf_d      = i_clr_err ? 1'b0 : unf_q;
    if (!i_stall) begin
      if (i_ret) begin
        if (lvl_q != '0) begin
          pc_d  = stack_q[IDX_W'(lvl_q - 1'b1)];
          lvl_d = lvl_q - 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end else if (i_call) begin
        if (full)    ovf_d      = 1'b1;
        if (!tgt_ok) addr_err_d = 1'b1;
        if (!full && tgt_ok) begin
          push  = 1'b1;
          pc_d  = i_target;
          lvl_d = lvl_q + 1'b1;
        end
      end else if (i_jump) begin
        if (tgt_ok) pc_d = i_target;
        else        addr_err_d = 1'b1;
      end else begin
        pc_d   = pc_inc;
        wrap_d = at_last;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      pc_q       <= '0;
      lvl_q      <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      addr_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      lvl_q      <= lvl_d;
      valid_q    <= 1'b1;
      wrap_q     <= wrap_d;
      addr_err_q <= addr_err_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Stack storage needs no reset: entries above the level are never read.
  always_ff @(posedge i_clk) begin
    if (push) stack_q[IDX_W'(lvl_q)] <= pc_inc;
  end

  assign o_pc        = pc_q;
  assign o_pc_valid  = valid_q;
  assign o_wrap      = wrap_q;
  assign o_addr_err  = addr_err_q;
  assign o_stack_ovf = ovf_q;
  assign o_stack_unf = unf_q;
  assign o_stack_lvl = lvl_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: hand-computed expectations for increment/wrap,
// call/ret nesting, error flags, priority and async reset.
module tb_pc_seq_unit;

  logic       i_clk = 1'b0;
  logic       i_nrst;
  logic       i_stall, i_jump, i_call, i_ret, i_clr_err;
  logic [7:0] i_target;
  logic [7:0] o_pc;
  logic       o_pc_valid, o_wrap, o_addr_err, o_stack_ovf, o_stack_unf;
  logic [2:0] o_stack_lvl;

  int n_tests = 0;
  int n_fail  = 0;

  pc_seq_unit #(.PC_BITS(8), .MEM_DEPTH(56), .STACK_DEPTH(4)) dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_stall     (i_stall),
    .i_jump      (i_jump),
    .i_call      (i_call),
    .i_ret       (i_ret),
    .i_target    (i_target),
    .i_clr_err   (i_clr_err),
    .o_pc        (o_pc),
    .o_pc_valid  (o_pc_valid),
    .o_wrap      (o_wrap),
    .o_addr_err  (o_addr_err),
    .o_stack_ovf (o_stack_ovf),
    .o_stack_unf (o_stack_unf),
    .o_stack_lvl (o_stack_lvl)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_stall = 0; i_jump = 0; i_call = 0; i_ret = 0; i_clr_err = 0; i_target = 8'd0;
  endtask

  // Advance one edge and settle; inputs are cleared for the next cycle.
  task automatic step();
    @(posedge i_clk);
    #1;
    idle();
  endtask

  task automatic do_call(input int tgt);
    i_call = 1; i_target = 8'(tgt); step();
  endtask

  task automatic do_ret();
    i_ret = 1; step();
  endtask

  task automatic do_jump(input int tgt);
    i_jump = 1; i_target = 8'(tgt); step();
  endtask

  task automatic chk_flags(input string tag, input int ae, input int ovf, input int unf);
    chk({tag, ".addr_err"}, o_addr_err, ae);
    chk({tag, ".ovf"}, o_stack_ovf, ovf);
    chk({tag, ".unf"}, o_stack_unf, unf);
  endtask

  initial begin
    idle();
    i_nrst = 0;
    #13;
    chk("rst.pc", o_pc, 0);
    chk("rst.valid", o_pc_valid, 0);
    chk("rst.wrap", o_wrap, 0);
    chk("rst.lvl", o_stack_lvl, 0);
    chk_flags("rst", 0, 0, 0);
    @(negedge i_clk);
    i_nrst = 1;

    // Sequential increment and wrap
    step();
    chk("inc1.pc", o_pc, 1);
    chk("inc1.valid", o_pc_valid, 1);
    for (int i = 0; i < 54; i++) step();
    chk("inc55.pc", o_pc, 55);
    chk("inc55.wrap", o_wrap, 0);
    step();
    chk("wrap.pc", o_pc, 0);
    chk("wrap.pulse", o_wrap, 1);
    step();
    chk("postwrap.pc", o_pc, 1);
    chk("postwrap.wrap", o_wrap, 0);

    // Single call / ret
    for (int i = 0; i < 4; i++) step();
    chk("pre_call.pc", o_pc, 5);
    do_call(20);
    chk("call.pc", o_pc, 20);
    chk("call.lvl", o_stack_lvl, 1);
    for (int i = 0; i < 3; i++) step();
    chk("sub.pc", o_pc, 23);
    do_ret();
    chk("ret.pc", o_pc, 6);
    chk("ret.lvl", o_stack_lvl, 0);

    // Nested calls and overflow
    do_call(10); do_call(11); do_call(12); do_call(13);
    chk("nest4.pc", o_pc, 13);
    chk("nest4.lvl", o_stack_lvl, 4);
    do_call(14);
    chk("ovf.pc", o_pc, 13);
    chk("ovf.lvl", o_stack_lvl, 4);
    chk_flags("ovf", 0, 1, 0);
    do_ret();
    chk("pop1.pc", o_pc, 13);
    chk("pop1.lvl", o_stack_lvl, 3);
    do_ret();
    chk("pop2.pc", o_pc, 12);
    do_ret();
    chk("pop3.pc", o_pc, 11);
    do_ret();
    chk("pop4.pc", o_pc, 7);
    chk("pop4.lvl", o_stack_lvl, 0);
    chk("pop4.ovf_sticky", o_stack_ovf, 1);
    i_clr_err = 1; step();
    chk_flags("clr1", 0, 0, 0);
    chk("clr1.pc", o_pc, 8);

    // Underflow and bad jump target
    do_jump(7);
    chk("jmp7.pc", o_pc, 7);
    do_ret();
    chk("unf.pc", o_pc, 7);
    chk_flags("unf", 0, 0, 1);
    do_jump(60);
    chk("badjmp.pc", o_pc, 7);
    chk_flags("badjmp", 1, 0, 1);

    // Priority
    i_stall = 1; i_jump = 1; i_target = 8'd30; step();
    chk("stall.pc", o_pc, 7);
    chk("stall.wrap", o_wrap, 0);
    do_call(40);
    chk("call40.pc", o_pc, 40);
    chk("call40.lvl", o_stack_lvl, 1);
    i_ret = 1; i_call = 1; i_target = 8'd50; step();
    chk("retcall.pc", o_pc, 8);
    chk("retcall.lvl", o_stack_lvl, 0);

    // Clear racing a new error: new error wins, other flags clear
    i_clr_err = 1; i_jump = 1; i_target = 8'd60; step();
    chk("clrrace.pc", o_pc, 8);
    chk_flags("clrrace", 1, 0, 0);
    i_clr_err = 1; i_stall = 1; step();
    chk("clrstall.pc", o_pc, 8);
    chk_flags("clrstall", 0, 0, 0);

    // Call at last address pushes wrapped return address
    do_jump(55);
    chk("jmp55.pc", o_pc, 55);
    do_call(2);
    chk("call_last.pc", o_pc, 2);
    do_ret();
    chk("ret_wrap.pc", o_pc, 0);
    chk("ret_wrap.wrap", o_wrap, 0);

    // Async reset mid-sequence
    do_call(3); do_call(4);
    chk("pre_rst.lvl", o_stack_lvl, 2);
    do_jump(60);
    chk("pre_rst.ae", o_addr_err, 1);
    #2;
    i_nrst = 0;
    #1;
    chk("arst.pc", o_pc, 0);
    chk("arst.lvl", o_stack_lvl, 0);
    chk("arst.valid", o_pc_valid, 0);
    chk_flags("arst", 0, 0, 0);
    @(negedge i_clk);
    i_nrst = 1;
    step();
    chk("rerun.pc", o_pc, 1);
    chk("rerun.valid", o_pc_valid, 1);
    chk("rerun.lvl", o_stack_lvl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter sequencer for the instruction-memory front end. It replaces the plain PC register with a sequencer that supports sequential increment with wrap at memory depth, absolute jump, subroutine call/return through an internal LIFO return stack, and stall. It also provides error and status flags. Output o_pc drives the instruction-memory address directly.

Parameters:
PC_BITS, 8, width of program counter and jump target
MEM_DEPTH, 56, number of valid instruction addresses (0..MEM_DEPTH-1); must satisfy MEM_DEPTH <= 2**PC_BITS
STACK_DEPTH, 4, number of return-address entries in call stack (>=1)

Ports:
i_clk  input  1  clock, rising-edge
i_nrst  input  1  reset, asynchronous, active-low
i_stall  input  1  hold PC and stack this cycle
i_jump  input  1  load PC with i_target
i_call  input  1  push return address, load PC with i_target
i_ret  input  1  pop return address into PC
i_target  input  PC_BITS  jump/call destination
i_clr_err  input  1  clear sticky error flags
o_pc  output  PC_BITS  current program counter (registered)
o_pc_valid  output  1  low from reset until first clock edge after reset release
o_wrap  output  1  one-cycle pulse: PC wrapped MEM_DEPTH-1 -> 0
o_addr_err  output  1  sticky: jump/call target >= MEM_DEPTH
o_stack_ovf  output  1  sticky: call with stack full
o_stack_unf  output  1  sticky: ret with stack empty
o_stack_lvl  output  $clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- Reset (async, i_nrst=0): o_pc=0, o_pc_valid=0, o_wrap=0, all sticky flags=0, o_stack_lvl=0, stack contents don't-care. Reset mid-operation discards the stack and any pending command immediately.
- o_pc_valid: set to 1 on first rising edge with i_nrst=1; stays 1 until next reset. The command inputs are evaluated on that same first edge.
- Latency: all commands are sampled on rising edge N; the new o_pc is visible after edge N (one cycle). There are no combinational input->output paths.
- Command priority per edge: i_stall > i_ret > i_call > i_jump > increment. Lower-priority commands asserted simultaneously are ignored.
- Stall: o_pc, stack and level are held. o_wrap=0. i_clr_err is still honoured.
- Increment (no command): o_pc <= (o_pc == MEM_DEPTH-1) ? 0 : o_pc+1. o_wrap=1 for exactly the cycle following the wrap edge, otherwise 0.
- Jump: if i_target < MEM_DEPTH, o_pc <= i_target. Otherwise o_pc holds and o_addr_err is set.
- Call: the return address is the next-sequential PC, computed with the same wrap rule as increment.
  - Target valid and level < STACK_DEPTH: push the return address, level+1, o_pc <= i_target.
  - Level == STACK_DEPTH: o_stack_ovf set; no push; o_pc holds.
  - Target invalid (and stack not full): o_addr_err set; no push; o_pc holds.
  - Both conditions true: both flags set.
- Ret: if level > 0, o_pc <= top entry and level-1. If level == 0, o_stack_unf is set and o_pc holds.
- Sticky flags: remain set until i_clr_err=1 is sampled or reset occurs. If a clear and a new error occur on the same edge, the new error wins (flag stays 1).
- Wrap never affects the stack. Pushed addresses are always < MEM_DEPTH.

Test Plan:
- Assert reset, then release with no commands -> o_pc=0 and o_pc_valid=0 during reset; after 1st edge o_pc=1, valid=1; after 55 edges o_pc=55; next edge o_pc=0 with o_wrap=1 for exactly one cycle.
- At PC=5, i_call with i_target=20 -> o_pc=20, lvl=1; increment 3 cycles (o_pc=23); i_ret -> o_pc=6, lvl=0.
- Five nested calls with targets 10,11,12,13,14 -> after 4th call lvl=4 and o_pc=13; 5th call leaves o_pc=13 with o_stack_ovf=1; four rets then restore return addresses in LIFO order; i_clr_err clears the flag.
- i_ret with lvl=0 at PC=7 -> o_pc stays 7, o_stack_unf=1. Then i_jump with i_target=60 -> o_pc stays 7, o_addr_err=1.
- Same edge: i_stall=1, i_jump=1, i_target=30 -> o_pc unchanged. Same edge: i_ret+i_call with lvl=1 -> ret executed, call ignored, lvl=0.
- Call at PC=55 (target 2) -> pushed return address is 0; on ret o_pc=0 and o_wrap=0. Then async reset mid-sequence with lvl=2 -> o_pc=0, lvl=0, flags 0 immediately without a clock edge.
